// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the FSM state-code checker: code widths, checker states
// and the successor function of the monitored 4-state cycle.
package fsm_seq_pkg;

  localparam int CODE_W     = 3;
  localparam int NUM_STATES = 4;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOCKED,
    LOST
  } chk_state_t;

  function automatic logic [1:0] next_code(input logic [1:0] prev);
    return prev + 2'd1;
  endfunction

endpackage

// File: rtl/fsm_seq_checker_if.sv
// Code-stream input and status outputs of the sequence checker.
// The checker is the slave; the observer/driver side is the master.
interface fsm_seq_checker_if
  import fsm_seq_pkg::*;
#(
  parameter int WRAP_W = 8
);

  logic              in_valid;
  logic [CODE_W-1:0] in_code;
  logic              clear;
  logic              locked;
  logic              err_pulse;
  logic              illegal_code;
  logic [1:0]        expected;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [7:0]        err_cnt;

  modport slave (
    input  in_valid, in_code, clear,
    output locked, err_pulse, illegal_code, expected, wrap_cnt, err_cnt
  );

  modport master (
    output in_valid, in_code, clear,
    input  locked, err_pulse, illegal_code, expected, wrap_cnt, err_cnt
  );

endinterface

// File: rtl/fsm_seq_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module fsm_seq_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/fsm_seq_checker.sv
// Receive-side checker for a cycling 0->1->2->3 state code: locks onto the stream,
// flags illegal codes/transitions, counts wraps and errors, and declares loss of lock.
module fsm_seq_checker
  import fsm_seq_pkg::*;
#(
  parameter int LOCK_CNT  = 4,
  parameter int ERR_LIMIT = 2,
  parameter int WRAP_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fsm_seq_checker_if.slave     bus
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W = $clog2(ERR_LIMIT + 1);

  chk_state_t        state_reg, state_next;
  logic [1:0]        prev_reg, prev_next;
  logic [RUN_W-1:0]  run_cnt_reg, run_cnt_next, run_inc;
  logic [BAD_W-1:0]  bad_cnt_reg, bad_cnt_next, bad_inc;
  logic              prev_we, err_next, wrap_inc;

  logic              locked_reg, err_pulse_reg, illegal_code_reg;
  logic [1:0]        expected_reg;
  logic [WRAP_W-1:0] wrap_cnt_reg;
  logic [7:0]        err_cnt;

  logic              code_hi, legal;
  logic [1:0]        code_lo;

  assign code_hi = bus.in_code[2];
  assign code_lo = bus.in_code[1:0];
  assign legal   = !code_hi && (code_lo == next_code(prev_reg));
  assign run_inc = run_cnt_reg + RUN_W'(1);
  assign bad_inc = bad_cnt_reg + BAD_W'(1);

  always_comb begin
    state_next   = state_reg;
    prev_next    = prev_reg;
    run_cnt_next = run_cnt_reg;
    bad_cnt_next = bad_cnt_reg;
    prev_we      = 1'b0;
    err_next     = 1'b0;
    wrap_inc     = 1'b0;
    case (state_reg)
      HUNT: begin
        if (bus.in_valid && !code_hi) begin
          prev_next    = code_lo;
          prev_we      = 1'b1;
          run_cnt_next = '0;
          state_next   = SYNC;
        end
      end
      SYNC: begin
        if (bus.in_valid) begin
          if (legal) begin
            prev_next    = code_lo;
            prev_we      = 1'b1;
            run_cnt_next = run_inc;
            if (run_inc == RUN_W'(LOCK_CNT)) begin
              state_next   = LOCKED;
              bad_cnt_next = '0;
            end
          end else if (!code_hi) begin
            prev_next    = code_lo;
            prev_we      = 1'b1;
            run_cnt_next = '0;
          end else begin
            state_next = HUNT;
          end
        end
      end
      LOCKED: begin
        if (bus.in_valid) begin
          if (legal) begin
            wrap_inc     = (prev_reg == 2'd3) && (code_lo == 2'd0);
            prev_next    = code_lo;
            prev_we      = 1'b1;
            bad_cnt_next = '0;
          end else begin
            // Flywheel: assume the source advanced anyway so a single glitch
            // does not make every following sample look wrong.
            err_next     = 1'b1;
            prev_next    = next_code(prev_reg);
            prev_we      = 1'b1;
            bad_cnt_next = bad_inc;
            if (bad_inc == BAD_W'(ERR_LIMIT)) begin
              state_next = LOST;
            end
          end
        end
      end
      LOST: begin
        state_next   = HUNT;
        run_cnt_next = '0;
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= HUNT;
      prev_reg         <= '0;
      run_cnt_reg      <= '0;
      bad_cnt_reg      <= '0;
      locked_reg       <= 1'b0;
      err_pulse_reg    <= 1'b0;
      illegal_code_reg <= 1'b0;
      expected_reg     <= '0;
      wrap_cnt_reg     <= '0;
    end else begin
      state_reg        <= state_next;
      prev_reg         <= prev_next;
      run_cnt_reg      <= run_cnt_next;
      bad_cnt_reg      <= bad_cnt_next;
      locked_reg       <= (state_next == LOCKED);
      err_pulse_reg    <= err_next;
      illegal_code_reg <= bus.in_valid && code_hi;
      if (prev_we) begin
        expected_reg <= next_code(prev_next);
      end
      if (bus.clear) begin
        wrap_cnt_reg <= '0;
      end else if (wrap_inc) begin
        wrap_cnt_reg <= wrap_cnt_reg + WRAP_W'(1);
      end
    end
  end

  fsm_seq_sat_cnt #(
    .W(8)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (bus.clear),
    .inc   (err_next),
    .count (err_cnt)
  );

  assign bus.locked       = locked_reg;
  assign bus.err_pulse    = err_pulse_reg;
  assign bus.illegal_code = illegal_code_reg;
  assign bus.expected     = expected_reg;
  assign bus.wrap_cnt     = wrap_cnt_reg;
  assign bus.err_cnt      = err_cnt;

endmodule
